// File: rtl/register_load_arbiter_if.sv
// Request/grant bundle between two writers, the arbiter and the shared 4-bit register.
// The master side is the requester/register environment; the slave side is the arbiter.
interface register_load_arbiter_if #(
    parameter int WIDTH     = 4,
    parameter int CNT_WIDTH = 4
);
    logic                 req_a;
    logic [WIDTH-1:0]     din_a;
    logic                 req_b;
    logic [WIDTH-1:0]     din_b;
    logic                 gnt_a;
    logic                 gnt_b;
    logic                 load;
    logic [WIDTH-1:0]     dout;
    logic                 last;
    logic [CNT_WIDTH-1:0] count;

    modport master (
        output req_a, din_a, req_b, din_b,
        input  gnt_a, gnt_b, load, dout, last, count
    );

    modport slave (
        input  req_a, din_a, req_b, din_b,
        output gnt_a, gnt_b, load, dout, last, count
    );
endinterface

// File: rtl/register_load_arbiter.sv
// Two-requester round-robin arbiter driving LOAD/DIN of a shared register.
// One grant per two cycles; keeps a saturating count of grants for debug.
module register_load_arbiter #(
    parameter int WIDTH     = 4,
    parameter int CNT_WIDTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    register_load_arbiter_if.slave bus
);
    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] GRANT = 1'b1;

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    logic [0:0]           state;
    logic                 gnt_a_q;
    logic                 gnt_b_q;
    logic                 load_q;
    logic                 last_q;
    logic [WIDTH-1:0]     dout_q;
    logic [CNT_WIDTH-1:0] count_q;

    logic                 pick_a;
    logic                 pick_b;

    // last_q = 1 means B won most recently, so A has priority on a tie.
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        pick_a = 1'b0;
        pick_b = 1'b0;
        if (state == IDLE) begin
            if (bus.req_a && (!bus.req_b || last_q)) begin
                pick_a = 1'b1;
            end else if (bus.req_b) begin
                pick_b = 1'b1;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            gnt_a_q <= 1'b0;
            gnt_b_q <= 1'b0;
            load_q  <= 1'b0;
            last_q  <= 1'b1;
            dout_q  <= '0;
            count_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_a || pick_b) begin
                        state   <= GRANT;
                        gnt_a_q <= pick_a;
                        gnt_b_q <= pick_b;
                        load_q  <= 1'b1;
                        dout_q  <= pick_a ? bus.din_a : bus.din_b;
                        last_q  <= pick_b;
                        if (count_q != CNT_MAX) begin
                            count_q <= count_q + 1'b1;
                        end
                    end else begin
                        gnt_a_q <= 1'b0;
                        gnt_b_q <= 1'b0;
                        load_q  <= 1'b0;
                    end
                end
                default: begin
                    // Grant lasts exactly one cycle; requests seen here are ignored.
                    state   <= IDLE;
                    gnt_a_q <= 1'b0;
                    gnt_b_q <= 1'b0;
                    load_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.gnt_a = gnt_a_q;
    assign bus.gnt_b = gnt_b_q;
    assign bus.load  = load_q;
    assign bus.dout  = dout_q;
    assign bus.last  = last_q;
    assign bus.count = count_q;
endmodule
